// File: rtl/irrigation_pkg.sv
// Shared tank sequencing types: state codes, level limits and fill target.
// The display selector imports the same state codes.
package irrigation_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILL     = 3'd1,
        IRRIGATE = 3'd2,
        MIX      = 3'd3,
        CLEAN    = 3'd4,
        FAULT    = 3'd5
    } stateT;

    typedef enum logic {
        TGT_IRRIGATE = 1'b0,
        TGT_MIX      = 1'b1
    } targetT;

    localparam logic [1:0] LVL_EMPTY = 2'd0;
    localparam logic [1:0] LVL_FULL  = 2'd3;

endpackage

// File: rtl/tank_cycle_scheduler_if.sv
// Sensor inputs and actuator/status outputs of the tank scheduler.
// The master side drives sensors; the slave side is the scheduler.
interface tank_cycle_scheduler_if;

    logic       Us;
    logic       Adub;
    logic [1:0] Lvl;
    logic       Ve;
    logic       Rega_en;
    logic       Mist;
    logic       Limp;
    logic       Busy;
    logic       Fault;
    logic [2:0] State;

    modport master (
        output Us, Adub, Lvl,
        input  Ve, Rega_en, Mist, Limp,
        input  Busy, Fault, State
    );

    modport slave (
        input  Us, Adub, Lvl,
        output Ve, Rega_en, Mist, Limp,
        output Busy, Fault, State
    );

endinterface

// File: rtl/tank_cycle_scheduler_tick_gen.sv
// Tick prescaler: one-cycle pulse every TICK_DIV clocks.
// A synchronous clear restarts the period from zero.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            cnt <= '0;
        else if (clr || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/tank_cycle_scheduler.sv
// Shared water tank scheduler: grants the tank to cleaning, mixing
// or irrigation, refills when low, and latches a fill-timeout fault.
module tank_cycle_scheduler
    import irrigation_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int FILL_TIMEOUT = 15,
    parameter int MIX_TICKS    = 8,
    parameter int CLEAN_TICKS  = 4
) (
    input  logic                   Clk,
    input  logic                   Rst,
    tank_cycle_scheduler_if.slave  io
);

    localparam logic [3:0] FILL_LAST  = 4'(FILL_TIMEOUT - 1);
    localparam logic [3:0] MIX_LAST   = 4'(MIX_TICKS - 1);
    localparam logic [3:0] CLEAN_LAST = 4'(CLEAN_TICKS - 1);

    stateT      state;
    targetT     target;
    logic       adubPrev;
    logic       adubPend;
    logic       cleanPend;
    logic [3:0] dwell;
    logic       tick;
    logic       leave;

    logic adubRise;
    logic adubReq;
    logic full;
    logic empty;

    assign adubRise = io.Adub & ~adubPrev;
    assign adubReq  = adubPend | adubRise;
    assign full     = (io.Lvl == LVL_FULL);
    assign empty    = (io.Lvl == LVL_EMPTY);

    // Any state change restarts the prescaler so dwells are exact
    always_comb begin
        leave = 1'b0;
        unique case (state)
            IDLE:     leave = cleanPend | adubReq | io.Us;
            FILL:     leave = full | (tick && dwell == FILL_LAST);
            IRRIGATE: leave = ~io.Us | empty;
            MIX:      leave = tick && dwell == MIX_LAST;
            CLEAN:    leave = tick && dwell == CLEAN_LAST;
            default:  leave = 1'b0;
        endcase
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .Clk  (Clk),
        .Rst  (Rst),
        .clr  (leave),
        .tick (tick)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            target    <= TGT_IRRIGATE;
            adubPrev  <= 1'b1;
            adubPend  <= 1'b0;
            cleanPend <= 1'b0;
            dwell     <= 4'd0;
        end else begin
            adubPrev <= io.Adub;
            if (adubRise)
                adubPend <= 1'b1;

            if (leave)
                dwell <= 4'd0;
            else if (tick && dwell != 4'hF)
                dwell <= dwell + 4'd1;

            // MIX entry clears adubPend after the edge-set above
            unique case (state)
                IDLE: begin
                    if (cleanPend) begin
                        state     <= CLEAN;
                        cleanPend <= 1'b0;
                    end else if (adubReq) begin
                        if (full) begin
                            state    <= MIX;
                            adubPend <= 1'b0;
                        end else begin
                            state  <= FILL;
                            target <= TGT_MIX;
                        end
                    end else if (io.Us) begin
                        if (!empty) begin
                            state <= IRRIGATE;
                        end else begin
                            state  <= FILL;
                            target <= TGT_IRRIGATE;
                        end
                    end
                end
                FILL: begin
                    if (full) begin
                        if (target == TGT_MIX) begin
                            state    <= MIX;
                            adubPend <= 1'b0;
                        end else begin
                            state <= IRRIGATE;
                        end
                    end else if (leave) begin
                        state <= FAULT;
                    end
                end
                IRRIGATE: begin
                    if (leave)
                        state <= IDLE;
                end
                MIX: begin
                    if (leave) begin
                        state     <= IDLE;
                        cleanPend <= 1'b1;
                    end
                end
                CLEAN: begin
                    if (leave)
                        state <= IDLE;
                end
                default: state <= FAULT;
            endcase
        end
    end

    assign io.Ve      = (state == FILL);
    assign io.Rega_en = (state == IRRIGATE);
    assign io.Mist    = (state == MIX);
    assign io.Limp    = (state == CLEAN);
    assign io.Busy    = (state != IDLE);
    assign io.Fault   = (state == FAULT);
    assign io.State   = state;

endmodule

// File: tb/tb_tank_cycle_scheduler.sv
// Scoreboard bench for tank_cycle_scheduler with a cycle-count
// reference model, directed scenarios and randomized stimulus.
module tb_tank_cycle_scheduler;

    localparam int TD = 4;
    localparam int FT = 15;
    localparam int MT = 8;
    localparam int CT = 4;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    tank_cycle_scheduler_if io ();

    tank_cycle_scheduler #(
        .TICK_DIV     (TD),
        .FILL_TIMEOUT (FT),
        .MIX_TICKS    (MT),
        .CLEAN_TICKS  (CT)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .io  (io.slave)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    logic [8:0] expQ[$];

    // Model: 0 idle, 1 fill, 2 irrigate, 3 mix, 4 clean, 5 fault
    int mState = 0;
    int mTgt = 2;
    int mCyc = 0;
    bit mAdubPend = 0;
    bit mCleanPend = 0;
    bit mPrev = 1;

    function automatic logic [8:0] outsOf(input int s);
        return {3'(s), s == 1, s == 2, s == 3, s == 4, s != 0, s == 5};
    endfunction

    function automatic logic [8:0] dutOuts();
        return {io.State, io.Ve, io.Rega_en, io.Mist,
                io.Limp, io.Busy, io.Fault};
    endfunction

    task automatic check(input string name,
                         input logic [8:0] got,
                         input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b t=%0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic modelStep(input bit us, input bit adub,
                             input logic [1:0] lvl, input bit rst);
        int nxt;
        int k;
        bit rise;
        if (!rst) begin
            mState = 0; mTgt = 2; mCyc = 0;
            mAdubPend = 0; mCleanPend = 0; mPrev = 1;
            return;
        end
        rise = adub && !mPrev;
        mPrev = adub;
        nxt = mState;
        k = mCyc + 1;
        case (mState)
            0: begin
                if (mCleanPend) begin
                    nxt = 4;
                    mCleanPend = 0;
                end else if (mAdubPend || rise) begin
                    if (lvl == 3) nxt = 3;
                    else begin nxt = 1; mTgt = 3; end
                end else if (us) begin
                    if (lvl != 0) nxt = 2;
                    else begin nxt = 1; mTgt = 2; end
                end
            end
            1: begin
                if (lvl == 3) nxt = mTgt;
                else if (k == FT * TD) nxt = 5;
            end
            2: if (!us || lvl == 0) nxt = 0;
            3: if (k == MT * TD) begin nxt = 0; mCleanPend = 1; end
            4: if (k == CT * TD) nxt = 0;
            default: ;
        endcase
        if (nxt == 3 && mState != 3) mAdubPend = 0;
        else if (rise) mAdubPend = 1;
        mCyc = (nxt != mState) ? 0 : k;
        mState = nxt;
    endtask

    task automatic cycle(input bit us, input bit adub,
                         input logic [1:0] lvl, input bit rst);
        @(negedge Clk);
        io.Us = us;
        io.Adub = adub;
        io.Lvl = lvl;
        Rst = rst;
        modelStep(us, adub, lvl, rst);
        expQ.push_back(outsOf(mState));
        if (!rst) begin
            #1;
            check("async_reset", dutOuts(), 9'd0);
        end
    endtask

    initial begin : monitor
        logic [8:0] e;
        forever begin
            @(posedge Clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("outputs", dutOuts(), e);
                checks++;
                if ($countones({io.Ve, io.Rega_en,
                                io.Mist, io.Limp}) > 1) begin
                    failures++;
                    $display("FAIL actuator_excl got=%b exp=at most one",
                             {io.Ve, io.Rega_en, io.Mist, io.Limp});
                end
            end
        end
    end

    initial begin : driver
        bit us;
        bit ad;
        bit rs;
        logic [1:0] lv;
        io.Us = 1'b1;
        io.Adub = 1'b0;
        io.Lvl = 2'd0;

        // Reset with demand and empty tank, then fill and irrigate
        repeat (3) cycle(1, 0, 0, 0);
        repeat (3) cycle(1, 0, 0, 1);
        repeat (3) cycle(1, 0, 3, 1);
        repeat (3) cycle(0, 0, 3, 1);

        // Mix then clean
        cycle(0, 1, 3, 1);
        repeat (60) cycle(0, 0, 3, 1);

        // Simultaneous Adub and Us: mix wins, irrigation after clean
        cycle(1, 1, 3, 1);
        repeat (60) cycle(1, 0, 3, 1);
        repeat (3) cycle(0, 0, 3, 1);

        // Fill timeout into sticky fault
        cycle(1, 0, 0, 1);
        repeat (70) cycle(1, 0, 1, 1);
        repeat (20) cycle(1'($urandom), 1'($urandom),
                          2'($urandom), 1);
        repeat (2) cycle(0, 0, 3, 0);
        repeat (2) cycle(0, 0, 3, 1);

        // Level reaches full on the timeout edge: level wins
        cycle(1, 0, 0, 1);
        repeat (59) cycle(1, 0, 1, 1);
        cycle(1, 0, 3, 1);
        repeat (3) cycle(0, 0, 3, 1);

        // Adub edge during irrigation
        repeat (3) cycle(1, 0, 3, 1);
        cycle(1, 1, 3, 1);
        repeat (10) cycle(1, 0, 3, 1);
        repeat (60) cycle(0, 0, 3, 1);

        // Reset mid-mix, then Adub high across reset release
        cycle(0, 1, 3, 1);
        repeat (10) cycle(0, 0, 3, 1);
        repeat (2) cycle(0, 1, 3, 0);
        repeat (20) cycle(0, 1, 3, 1);
        repeat (3) cycle(0, 0, 3, 1);

        us = 0;
        lv = 2'd3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) us = ~us;
            if ($urandom_range(0, 7) == 0) lv = 2'($urandom);
            ad = ($urandom_range(0, 24) == 0);
            rs = ($urandom_range(0, 299) != 0);
            cycle(us, ad, lv, rs);
        end

        @(posedge Clk);
        #3;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d exp=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
